// File: rtl/axi_slave_write_ctrl.sv
// axi_slave_write_ctrl
//   AXI4 slave write-channel controller. Accepts one burst at a time on AW,
//   generates per-beat memory addresses for FIXED/INCR/WRAP bursts, forwards
//   W beats to a local memory write port under write_ready backpressure, and
//   returns a B response carrying the captured ID and OKAY/SLVERR.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   s_axi_aresetn       : AXI soft reset, active-low, sampled on clk
//   s_axi_aw*           : write address channel (slave side)
//   s_axi_w*            : write data channel (slave side)
//   s_axi_b*            : write response channel (slave side)
//   write_ready         : memory can take a beat this cycle
//   mem_w*              : memory write port (combinational from W inputs)
//   tx_wactive/tx_bwait : status, data phase / response pending
//   tx_beat             : beats accepted in the current burst (saturating)
module axi_slave_write_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axi_aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic                write_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                tx_wactive,
  output logic                tx_bwait,
  output logic [7:0]          tx_beat
);

  localparam int STRB_W = DATA_W / 8;
  // Largest legal awsize for this data width (log2 of bytes per beat).
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              aw_err_q, aw_err_d;
  logic              wlast_err_q, wlast_err_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [7:0]        beat_q, beat_d;

  // Decode checks on the AW channel, evaluated at capture time.
  logic [ADDR_W-1:0] aw_size_mask;
  logic              size_err, wrap_err, aw_err_now;

  assign aw_size_mask = (ADDR_W'(1) << s_axi_awsize) - ADDR_W'(1);
  assign size_err     = (s_axi_awsize > SIZE_MAX);
  assign wrap_err     = (s_axi_awburst == 2'b10) &&
                        (!(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                         (|(s_axi_awaddr & aw_size_mask)));
  assign aw_err_now   = (s_axi_awburst == 2'b11) || size_err || wrap_err;

  // Beat bookkeeping.
  logic beat_acc, last_beat, wlast_bad;
  assign beat_acc  = (state_q == DATA) && s_axi_wvalid && write_ready;
  assign last_beat = (beat_q == len_q);
  // wlast must be high exactly on the beat that the count says is final.
  assign wlast_bad = (s_axi_wlast != last_beat);

  // Next address for the beat after the current one.
  logic [ADDR_W-1:0] step, wrap_bytes, wrap_mask, addr_incr, addr_next;
  assign step       = ADDR_W'(1) << size_q;
  assign wrap_bytes = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
  assign wrap_mask  = wrap_bytes - ADDR_W'(1);
  assign addr_incr  = addr_q + step;

  always_comb begin
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
      default: addr_next = addr_incr;  // INCR and reserved type
    endcase
  end

  // State register (plus captured burst context). Soft reset wins over
  // every transition and silently abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      aw_err_q    <= 1'b0;
      wlast_err_q <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      beat_q      <= '0;
    end else if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      aw_err_q    <= 1'b0;
      wlast_err_q <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      aw_err_q    <= aw_err_d;
      wlast_err_q <= wlast_err_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      beat_q      <= beat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    aw_err_d    = aw_err_q;
    wlast_err_d = wlast_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    beat_d      = beat_q;
    case (state_q)
      IDLE: begin
        if (s_axi_awvalid) begin
          state_d     = DATA;
          addr_d      = s_axi_awaddr;
          len_d       = s_axi_awlen;
          size_d      = s_axi_awsize;
          burst_d     = s_axi_awburst;
          aw_err_d    = aw_err_now;
          wlast_err_d = 1'b0;
          bid_d       = s_axi_awid;
          beat_d      = 8'd0;
        end
      end
      DATA: begin
        if (beat_acc) begin
          if (beat_q != 8'hFF) beat_d = beat_q + 8'd1;
          addr_d = addr_next;
          if (wlast_bad) wlast_err_d = 1'b1;
          if (last_beat) begin
            state_d = RESP;
            // Include the final beat's own wlast check, not yet registered.
            bresp_d = (aw_err_q || wlast_err_q || wlast_bad) ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (s_axi_bready) begin
          state_d = IDLE;
          bresp_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    s_axi_awready = (state_q == IDLE);
    tx_wactive    = (state_q == DATA);
    tx_bwait      = (state_q == RESP);
    s_axi_bvalid  = (state_q == RESP);
    s_axi_wready  = (state_q == DATA) && write_ready;
    mem_wen       = beat_acc && !aw_err_q;
    mem_waddr     = addr_q;
    mem_wdata     = s_axi_wdata;
    mem_wstrb     = s_axi_wstrb;
    s_axi_bid     = bid_q;
    s_axi_bresp   = bresp_q;
    tx_beat       = beat_q;
  end

endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
module tb_axi_slave_write_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_axi_aresetn;
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic              write_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              tx_wactive;
  logic              tx_bwait;
  logic [7:0]        tx_beat;

  axi_slave_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .write_ready(write_ready),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .tx_wactive(tx_wactive), .tx_bwait(tx_bwait), .tx_beat(tx_beat)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [11:0] id; logic [1:0] resp; } b_t;
  wr_t wq[$];
  b_t  bq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Reference model: byte address of beat i, from the burst rules directly.
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                             input int size, input int burst, input int i);
    longint s, b, base, a;
    s = longint'(1) << size;
    a = longint'(addr);
    if (burst == 0) return addr;
    if (burst == 2) begin
      b    = (len + 1) * s;
      base = a - (a % b);
      return 32'(base + ((a - base + i * s) % b));
    end
    return 32'((a + i * s) % (longint'(1) << 32));
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input int len,
                                   input int size, input int burst);
    int s;
    s = 1 << size;
    if (burst == 3) return 1'b1;
    if (s > DATA_W / 8) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2 && (addr % s) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write or a B.
  always @(negedge clk) begin
    if (mem_wen) begin
      if (wq.size() == 0) fail_now("unexpected_mem_write");
      else begin
        wr_t e;
        e = wq.pop_front();
        check("mem_waddr", 64'(mem_waddr), 64'(e.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e.data));
        check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
        $display("write addr=%h data=%h strb=%h", mem_waddr, mem_wdata, mem_wstrb);
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) fail_now("unexpected_b");
      else begin
        b_t e;
        e = bq.pop_front();
        check("bid", 64'(s_axi_bid), 64'(e.id));
        check("bresp", 64'(s_axi_bresp), 64'(e.resp));
        $display("bresp id=%h resp=%0d", s_axi_bid, s_axi_bresp);
      end
    end
  end

  // AW handshake only; returns at posedge+1 after the handshake edge.
  task automatic aw_only(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (s_axi_awready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("aw_timeout");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_txn(input logic [11:0] id, input logic [31:0] addr, input int len,
                        input int size, input int burst, input int bad_beat,
                        input bit wr_rand, input int bdelay);
    bit err, acc;
    logic [1:0] resp;
    logic [31:0] r;
    int exp_beat;
    err  = model_err(addr, len, size, burst);
    resp = (err || (bad_beat >= 0 && bad_beat <= len)) ? 2'b10 : 2'b00;
    bq.push_back('{id, resp});
    aw_only(id, addr, 8'(len), 3'(size), 2'(burst));
    @(negedge clk);
    check("aw_to_data_wactive", 64'(tx_wactive), 64'd1);
    check("aw_to_data_awready", 64'(s_axi_awready), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= len; i++) begin
      r = $urandom;
      s_axi_wdata  = r;
      r = $urandom;
      s_axi_wstrb  = r[3:0];
      s_axi_wlast  = (i == len) ^ (i == bad_beat);
      s_axi_wvalid = 1'b1;
      if (!err) wq.push_back('{model_addr(addr, len, size, burst, i), s_axi_wdata, s_axi_wstrb});
      write_ready = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        check("wready_follows", 64'(s_axi_wready), 64'(write_ready));
        if (s_axi_wready) begin acc = 1'b1; @(posedge clk); #1; break; end
        @(posedge clk); #1;
        write_ready = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (!acc) fail_now("w_beat_timeout");
    end
    // Keep W valid with junk during the response phase: it must be ignored.
    s_axi_wlast = 1'b0;
    write_ready = 1'b1;
    exp_beat = (len + 1 > 255) ? 255 : len + 1;
    @(negedge clk);
    check("resp_bvalid", 64'(s_axi_bvalid), 64'd1);
    check("resp_wactive", 64'(tx_wactive), 64'd0);
    check("tx_beat", 64'(tx_beat), 64'(exp_beat));
    repeat (bdelay) begin
      @(negedge clk);
      check("hold_bvalid", 64'(s_axi_bvalid), 64'd1);
      check("hold_bid", 64'(s_axi_bid), 64'(id));
      check("hold_bresp", 64'(s_axi_bresp), 64'(resp));
      check("hold_awready", 64'(s_axi_awready), 64'd0);
      check("resp_wready", 64'(s_axi_wready), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    s_axi_wvalid = 1'b0;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    check("post_b_awready", 64'(s_axi_awready), 64'd1);
    check("post_b_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("post_b_bresp", 64'(s_axi_bresp), 64'd0);
    @(posedge clk); #1;
  endtask

  localparam int NB = 6;

  initial begin
    logic [11:0] ids[NB];
    logic [31:0] ads[NB], dts[NB];
    int k;
    bit hs;

    rst = 1'b1; s_axi_aresetn = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; write_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_awready", 64'(s_axi_awready), 64'd1);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_bid", 64'(s_axi_bid), 64'd0);
    check("rst_bresp", 64'(s_axi_bresp), 64'd0);
    check("rst_wactive", 64'(tx_wactive), 64'd0);
    check("rst_bwait", 64'(tx_bwait), 64'd0);
    check("rst_tx_beat", 64'(tx_beat), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-burst: outputs return immediately, no B.
    aw_only(12'h333, 32'h40, 8'd3, 3'd2, 2'd1);
    #3 rst = 1'b1;
    #1;
    check("async_awready", 64'(s_axi_awready), 64'd1);
    check("async_wactive", 64'(tx_wactive), 64'd0);
    check("async_bid", 64'(s_axi_bid), 64'd0);
    check("async_bvalid", 64'(s_axi_bvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Soft reset during DATA: IDLE at the next edge, no B afterwards.
    aw_only(12'h444, 32'h80, 8'd1, 3'd2, 2'd1);
    s_axi_aresetn = 1'b0;
    @(posedge clk); #1;
    s_axi_aresetn = 1'b1;
    s_axi_bready = 1'b1;
    @(negedge clk);
    check("soft_awready", 64'(s_axi_awready), 64'd1);
    check("soft_wactive", 64'(tx_wactive), 64'd0);
    check("soft_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("soft_bid", 64'(s_axi_bid), 64'd0);
    repeat (3) @(posedge clk);
    #1 s_axi_bready = 1'b0;

    // Directed bursts.
    do_txn(12'h05A, 32'h100, 3, 2, 1, -1, 1'b0, 0);   // INCR
    do_txn(12'h011, 32'h038, 3, 2, 2, -1, 1'b0, 0);   // WRAP
    do_txn(12'h022, 32'h200, 2, 2, 0, -1, 1'b0, 1);   // FIXED
    do_txn(12'h033, 32'h300, 1, 2, 1, -1, 1'b1, 5);   // backpressure + bready hold
    do_txn(12'h044, 32'h400, 0, 3, 1, -1, 1'b0, 0);   // size too large
    do_txn(12'h055, 32'h500, 1, 2, 1,  0, 1'b0, 0);   // early wlast
    do_txn(12'h066, 32'h600, 1, 2, 3, -1, 1'b0, 0);   // reserved burst
    do_txn(12'h077, 32'hFFFF_FFFC, 1, 2, 1, -1, 1'b0, 0); // INCR address rollover

    // Randomised bursts.
    for (int n = 0; n < 25; n++) begin
      int sz, bu, ln, bb;
      logic [31:0] ad, r;
      logic [11:0] id;
      sz = $urandom_range(0, 3);
      bu = $urandom_range(0, 3);
      if (bu == 2 && $urandom_range(0, 4) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 7);
      r  = $urandom;
      ad = r;
      if ($urandom_range(0, 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      bb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ln) : -1;
      r  = $urandom;
      id = r[11:0];
      do_txn(id, ad, ln, sz, bu, bb, 1'b1, $urandom_range(0, 3));
    end

    // Back-to-back single-beat transactions: one every 3 cycles.
    for (int i = 0; i < NB; i++) begin
      logic [31:0] r;
      r = $urandom; ids[i] = r[11:0];
      r = $urandom; ads[i] = r & 32'hFFFF_FFFC;
      dts[i] = $urandom;
      wq.push_back('{ads[i], dts[i], 4'hF});
      bq.push_back('{ids[i], 2'b00});
    end
    s_axi_awid = ids[0]; s_axi_awaddr = ads[0]; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wstrb = 4'hF; s_axi_wdata = '0;
    write_ready = 1'b1; s_axi_bready = 1'b1;
    k = 0;
    for (int c = 0; c < 3 * NB; c++) begin
      @(negedge clk);
      check("b2b_awready", 64'(s_axi_awready), 64'((c % 3) == 0));
      hs = s_axi_awvalid && s_axi_awready;
      @(posedge clk); #1;
      if (hs) begin
        s_axi_wdata = dts[k];
        k++;
        if (k < NB) begin s_axi_awid = ids[k]; s_axi_awaddr = ads[k]; end
        else s_axi_awvalid = 1'b0;
      end
    end
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("wq_drained", 64'(wq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
